// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, framebuffer geometry and colour type
package vga_pkg;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_COLS    = 40;
  localparam int FB_ROWS    = 30;
  localparam int CELL_SHIFT = 4;
  localparam int FB_BITS    = FB_COLS * FB_ROWS;
  typedef logic [11:0] rgb_t;
  // row*40 + col, built from shifts since 40 = 32 + 8
  function automatic logic [10:0] cell_index(input logic [4:0] row, input logic [5:0] col);
    return 11'({row, 5'b0}) + 11'({row, 3'b0}) + 11'(col);
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: 25 MHz pixel tick, 800x525 raster counters and raw sync/visible/wrap flags
module vga_timing
  import vga_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  output logic       pix_en,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       visible,
  output logic       frame_wrap
);
  logic h_end, v_end;
  assign h_end = hcount == 10'(H_TOTAL - 1);
  assign v_end = vcount == 10'(V_TOTAL - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pix_en <= 1'b0;
      hcount <= '0;
      vcount <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        hcount <= h_end ? '0 : hcount + 10'd1;
        if (h_end) vcount <= v_end ? '0 : vcount + 10'd1;
      end
    end
  assign hs_raw     = !(hcount >= 10'(H_VIS + H_FP) && hcount < 10'(H_VIS + H_FP + H_SYNC));
  assign vs_raw     = !(vcount >= 10'(V_VIS + V_FP) && vcount < 10'(V_VIS + V_FP + V_SYNC));
  assign visible    = hcount < 10'(H_VIS) && vcount < 10'(V_VIS);
  assign frame_wrap = h_end && v_end;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: scans a per-frame snapshot of the 40x30 framebuffer to VGA as 16x16 pixel blocks
module vga_scanout
  import vga_pkg::*;
#(
  parameter rgb_t FG_RGB = 12'hFFF,
  parameter rgb_t BG_RGB = 12'h000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FB_BITS-1:0] framebuffer,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start
);
  logic               pix_en, hs_raw, vs_raw, visible, frame_wrap;
  logic [9:0]         hcount, vcount;
  logic [FB_BITS-1:0] snap;
  logic [10:0]        idx;
  rgb_t               colour;
  vga_timing u_timing (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .visible    (visible),
    .frame_wrap (frame_wrap)
  );
  assign idx = cell_index(5'(vcount >> CELL_SHIFT), 6'(hcount >> CELL_SHIFT));
  always_comb colour = !visible ? '0 : snap[idx] ? FG_RGB : BG_RGB;
  // snap reloads on the wrap tick so the new image starts exactly at pixel (0,0)
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      snap                  <= '0;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
      {vga_r, vga_g, vga_b} <= '0;
      frame_start           <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_wrap;
      if (pix_en) begin
        if (frame_wrap) snap <= framebuffer;
        vga_hs                <= hs_raw;
        vga_vs                <= vs_raw;
        {vga_r, vga_g, vga_b} <= colour;
      end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized framebuffer images checked against a raster-position model of the scan
module tb_vga_scanout;
  localparam int CLK_FRAME = 840000;
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1199:0] framebuffer = '0;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, frame_start;
  int            n_checks = 0;
  int            n_fails = 0;
  int            e = 0;
  logic [1199:0] img = '0;
  int            hs_fall = -1;
  int            vs_fall = -1;
  logic          hs_q = 1'b1;
  logic          vs_q = 1'b1;

  vga_scanout dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .framebuffer (framebuffer),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  always #10 clock = ~clock;

  task automatic finish_up;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (clock %0d after reset)", tag, got, exp, e);
      if (n_fails >= 20) finish_up();
    end
  endtask

  function automatic logic [1199:0] rand_img();
    logic [1199:0] r;
    for (int i = 0; i < 1200; i++) r[i] = 1'($urandom_range(1));
    return r;
  endfunction

  function automatic bit hot_line(input int v);
    return v inside {0, 15, 16, 31, 32, 100, 200, 464, 479, 480, 489, 490, 491, 492, 524};
  endfunction

  // e counts clock edges since reset release; the image changes at every 840000th edge
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      e   <= 0;
      img <= '0;
    end else begin
      e <= e + 1;
      if ((e + 1) % CLK_FRAME == 0) img <= framebuffer;
    end

  // outputs after edge e show raster position e/2-1 (one tick behind the counters)
  always @(negedge clock) begin
    int p, h, v;
    logic vis, ehs, evs, efs;
    logic [11:0] ergb;
    p = e / 2 - 1;
    h = p < 0 ? 0 : p % 800;
    v = p < 0 ? 0 : (p / 800) % 525;
    if (p < 0 || hot_line(v) || $urandom_range(63) == 0) begin
      vis  = p >= 0 && h < 640 && v < 480;
      ergb = vis ? (img[(v / 16) * 40 + h / 16] ? 12'hFFF : 12'h000) : 12'h000;
      ehs  = !(p >= 0 && h >= 656 && h < 752);
      evs  = !(p >= 0 && v >= 490 && v < 492);
      efs  = e > 0 && e % CLK_FRAME == 0;
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(ergb));
      check("hs", 32'(vga_hs), 32'(ehs));
      check("vs", 32'(vga_vs), 32'(evs));
      check("frame_start", 32'(frame_start), 32'(efs));
    end
  end

  always @(negedge clock)
    if (!reset_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_fall <= -1;
      vs_fall <= -1;
    end else begin
      hs_q <= vga_hs;
      vs_q <= vga_vs;
      if (hs_q && !vga_hs) begin
        if (hs_fall < 0) check("hs_first_fall", 32'(e), 32'd1314);
        else check("hs_period", 32'(e - hs_fall), 32'd1600);
        hs_fall <= e;
      end
      if (!hs_q && vga_hs && hs_fall >= 0) check("hs_low", 32'(e - hs_fall), 32'd192);
      if (vs_q && !vga_vs) begin
        if (vs_fall >= 0) check("vs_period", 32'(e - vs_fall), 32'(CLK_FRAME));
        vs_fall <= e;
      end
      if (!vs_q && vga_vs && vs_fall >= 0) check("vs_low", 32'(e - vs_fall), 32'd3200);
    end

  initial begin
    logic [1199:0] b;
    repeat (10) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    framebuffer = rand_img();
    wait (e == CLK_FRAME - 1);
    @(negedge clock);
    b = rand_img();
    b[0] = 1'b1;
    b[1199] = 1'b1;
    framebuffer = b;
    wait (e == CLK_FRAME);
    @(negedge clock) framebuffer = rand_img();
    wait (e == CLK_FRAME + 160000);
    @(negedge clock);
    b = rand_img();
    b[41] = 1'b1;
    b[498] = 1'b1;
    framebuffer = b;
    wait (e == 2000600);
    #3;
    check("pre_reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFFF);
    reset_n = 1'b0;
    #1;
    check("async_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("async_hs", 32'(vga_hs), 32'h1);
    check("async_vs", 32'(vga_vs), 32'h1);
    check("async_fs", 32'(frame_start), 32'h0);
    repeat (10) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    wait (e == 40000);
    @(negedge clock);
    finish_up();
  end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Reads the 1200-bit, 40×30 monochrome framebuffer produced by the letter renderer and scans it out to the DE0 VGA connector at 640×480 @ 60 Hz. Each framebuffer bit is expanded to a 16×16 pixel block. The block snapshots the framebuffer once per frame so that mid-frame letter movement cannot tear. It sits between the renderer and the board VGA pins, and provides a frame-start strobe that the game logic uses as its tick.

## Interface
Parameters:
- FG_RGB, 12'hFFF, colour of a set bit ({R,G,B}, 4 bits each).
- BG_RGB, 12'h000, colour of a clear bit.

Ports:
- clock  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- framebuffer  in  1200  bit index = row*40 + col; row 0 is the top row and col 0 is the leftmost column.
- vga_r, vga_g, vga_b  out  4 each  pixel colour; forced to 0 outside the visible area.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- frame_start  out  1  one-clock pulse when the counters wrap to (0,0).

## Operation
- Pixel enable pix_en toggles every clock, giving a 25 MHz tick. Counters, the snapshot and the outputs advance only on clocks where pix_en=1.
- hcount counts 0..799 and wraps to 0. vcount increments when hcount wraps, counts 0..524 and wraps to 0. Both counters are 10 bits.
- Horizontal timing, in ticks: visible 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- Vertical timing, in lines: visible 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- Visible when hcount<640 and vcount<480.
  - col = hcount[9:4] (0..39).
  - row = vcount[8:4] (0..29).
  - idx = row*40 + col, an 11-bit value with maximum 1199.
- snap is a 1200-bit register loaded from framebuffer on the tick where hcount=799 and vcount=524. Only this load reads framebuffer; all pixel lookup uses snap.
- Colour = FG_RGB if snap[idx]=1, else BG_RGB. Colour is 0 in blanking.
- frame_start is asserted for one clock on the same tick that snap loads.

## Timing
- Reset values: hcount=0, vcount=0, pix_en=0, snap=0, vga_hs=1, vga_vs=1, vga_r/g/b=0, frame_start=0.
- Reset is asynchronous: outputs take their reset values immediately, with no wait for a clock edge.
- After reset release:
  - The first pix_en=1 clock is the second rising edge.
  - The first frame displays all BG, because snap=0.
- Latency: the outputs are registered, so colour, vga_hs and vga_vs all appear one pixel tick after the counter values that produce them. Sync and colour stay mutually aligned.
- Periods:
  - vga_hs is low for exactly 96 ticks (192 clocks) out of every 800 ticks (1600 clocks).
  - vga_vs is low for 2 lines out of every 525 lines; a frame is 840000 clocks.
- Boundary behaviour:
  - Counter wrap at (799,524) and the snap load happen in the same tick; the new image starts at pixel (0,0).
  - A framebuffer change in the same clock as the load is captured.
  - A change one clock later waits a full frame.
  - Reset asserted mid-frame clears snap, both counters and the outputs; the scan restarts at (0,0) after release.
- There is no handshake with the renderer, and framebuffer is sampled only at the load tick. The renderer is combinational from synchronous game state, so no CDC applies.

## Structure
- Shared package vga_pkg:
  - horizontal and vertical timing constants (H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP, H_TOTAL, V_TOTAL);
  - FB_COLS=40, FB_ROWS=30, CELL_SHIFT=4;
  - a 12-bit rgb type.
- One sub-module, vga_timing: generates pix_en, hcount, vcount, raw hs/vs, visible and frame_wrap.
- vga_scanout owns snap, the index computation, the colour mux and the output registers.

## Test plan
- Reset: hold reset_n low for 10 clocks, then release. During reset vga_hs=vga_vs=1 and RGB=0. The first frame is all 0x000 in the visible area.
- Horizontal: measure vga_hs.
  - Falling edges are 1600 clocks apart and the low width is 192 clocks.
  - The falling edge is 656 ticks after the first visible pixel of the line, i.e. 656 ticks from (0,y).
- Vertical:
  - vga_vs falling edges are 840000 clocks apart and the low width is 2×1600 clocks.
  - frame_start pulses once per frame, 1 clock wide.
- Mapping:
  - framebuffer bit 0 = 1, all others 0 → next frame shows 0xFFF exactly at x 0–15, y 0–15.
  - Bit 1199 only → 0xFFF exactly at x 624–639, y 464–479.
  - All other visible pixels 0x000 and blanking 0.
- Snapshot: set bit 41 mid-frame at line 100.
  - The current frame is unchanged.
  - The following frame shows a block at x 16–31, y 16–31.
- Mid-frame reset: assert reset_n low at line 200, tick 300.
  - Outputs reach their reset values within the same clock.
  - After release the scan restarts at (0,0) and the first frame is blank.
